// File: rtl/reward.sv
// reward: builds the REWARD (or SOS) reply for a DATA packet that this node
// received from a known neighbour, then pulses reward_done for one cycle.
// Optional feature macro: REWARD_NBR_CHECK_EN. When defined, the sender is
// looked up in the neighbour table (SCAN state) before a reply is built.
// When undefined, every qualifying DATA packet is answered directly and the
// table index output is tied to zero.
module reward #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [2:0]            fPacketType,
    input  logic [WORD_WIDTH-1:0] myEnergy,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] hopsFromSink,
    input  logic [WORD_WIDTH-1:0] myQValue,
    input  logic                  iHaveData,
    input  logic                  iAmDestination,
    input  logic                  role,
    input  logic                  low_E,
    input  logic [WORD_WIDTH-1:0] fSourceID,
    input  logic [WORD_WIDTH-1:0] fSourceHops,
    input  logic [WORD_WIDTH-1:0] fQValue,
    input  logic [WORD_WIDTH-1:0] fEnergyLeft,
    input  logic [WORD_WIDTH-1:0] fHopsFromCH,
    input  logic [WORD_WIDTH-1:0] fChosenCH,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    input  logic [WORD_WIDTH-1:0] chosenHop,
    input  logic [4:0]            neighborCount,
    input  logic [WORD_WIDTH-1:0] mNodeID,
    input  logic [WORD_WIDTH-1:0] mNodeHops,
    input  logic [WORD_WIDTH-1:0] mNodeQValue,
    input  logic [WORD_WIDTH-1:0] mNodeEnergy,
    input  logic [WORD_WIDTH-1:0] mNodeCHHops,
    output logic [WORD_WIDTH-1:0] rSourceID,
    output logic [WORD_WIDTH-1:0] rEnergyLeft,
    output logic [WORD_WIDTH-1:0] rQValue,
    output logic [WORD_WIDTH-1:0] rSourceHops,
    output logic [WORD_WIDTH-1:0] rDestinationID,
    output logic [WORD_WIDTH-1:0] rChosenCH,
    output logic [WORD_WIDTH-1:0] rHopsFromCH,
    output logic [2:0]            rPacketType,
    output logic [5:0]            nTableIndex_reward,
    output logic                  reward_done
);

    localparam logic [2:0] PKT_NONE   = 3'd0;
    localparam logic [2:0] PKT_DATA   = 3'd5;
    localparam logic [2:0] PKT_REWARD = 3'd6;
    localparam logic [2:0] PKT_SOS    = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BUILD = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Outgoing packet, held between operations
    typedef struct packed {
        logic [WORD_WIDTH-1:0] srcId;
        logic [WORD_WIDTH-1:0] energy;
        logic [WORD_WIDTH-1:0] qValue;
        logic [WORD_WIDTH-1:0] srcHops;
        logic [WORD_WIDTH-1:0] destId;
        logic [WORD_WIDTH-1:0] chosenCh;
        logic [WORD_WIDTH-1:0] hopsCh;
        logic [2:0]            pktType;
    } rewardPkt_t;

    state_t                state, stateNext;
    rewardPkt_t            pkt;
    logic [WORD_WIDTH-1:0] srcIdLat;
    logic [2:0]            typeLat;
    logic                  destLat;
    logic                  accept;

    // A reply is only ever considered for DATA addressed to this node
    assign accept = en && (fPacketType == PKT_DATA) && iAmDestination;

`ifdef REWARD_NBR_CHECK_EN
    logic [5:0] idx;
    logic [5:0] lastIdx;
    logic       nbrEmpty;
    logic       nbrMatch;
    logic       scanEnd;

    // An empty table ends the scan at once, even if the stale entry matches
    assign lastIdx  = {1'b0, neighborCount} - 6'd1;
    assign nbrEmpty = (neighborCount == 5'd0);
    assign nbrMatch = !nbrEmpty && (mNodeID == srcIdLat);
    assign scanEnd  = nbrEmpty || (!nbrMatch && (idx == lastIdx));

    // Table walk index: starts at 0, advances on miss, holds on hit
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx <= '0;
        end else begin
            case (state)
                IDLE:    if (accept) idx <= '0;
                SCAN:    if (!nbrMatch && !scanEnd) idx <= idx + 6'd1;
                DONE:    idx <= '0;
                default: ;
            endcase
        end
    end

    assign nTableIndex_reward = idx;
`else
    assign nTableIndex_reward = '0;
`endif

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state logic; en outside IDLE is dropped, not queued
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (en) begin
`ifdef REWARD_NBR_CHECK_EN
                    stateNext = accept ? SCAN : DONE;
`else
                    stateNext = accept ? BUILD : DONE;
`endif
                end
            end
`ifdef REWARD_NBR_CHECK_EN
            SCAN: begin
                if (nbrMatch)     stateNext = BUILD;
                else if (scanEnd) stateNext = DONE;
            end
`endif
            BUILD:   stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Completion pulse is a pure decode of DONE, so reset kills it at once
    always_comb begin
        reward_done = 1'b0;
        if (state == DONE) reward_done = 1'b1;
    end

    // Packet assembly and received-header latch
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pkt      <= '0;
            srcIdLat <= '0;
            typeLat  <= '0;
            destLat  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        srcIdLat <= fSourceID;
                        typeLat  <= fPacketType;
                        destLat  <= iAmDestination;
                        if (!accept) pkt.pktType <= PKT_NONE;
                    end
                end
`ifdef REWARD_NBR_CHECK_EN
                SCAN: begin
                    if (!nbrMatch && scanEnd) pkt.pktType <= PKT_NONE;
                end
`endif
                BUILD: begin
                    pkt.srcId    <= myNodeID;
                    pkt.energy   <= myEnergy;
                    pkt.qValue   <= myQValue;
                    pkt.srcHops  <= hopsFromSink;
                    pkt.destId   <= srcIdLat;
                    // A cluster head advertises itself at zero hops
                    pkt.chosenCh <= role ? myNodeID : chosenCH;
                    pkt.hopsCh   <= role ? '0 : hopsFromCH;
                    pkt.pktType  <= low_E ? PKT_SOS : PKT_REWARD;
                end
                default: ;
            endcase
        end
    end

    assign rSourceID      = pkt.srcId;
    assign rEnergyLeft    = pkt.energy;
    assign rQValue        = pkt.qValue;
    assign rSourceHops    = pkt.srcHops;
    assign rDestinationID = pkt.destId;
    assign rChosenCH      = pkt.chosenCh;
    assign rHopsFromCH    = pkt.hopsCh;
    assign rPacketType    = pkt.pktType;

    // Status-only inputs and the latched header copy are kept for debug
    // visibility; they do not steer the reply
    logic unusedSigs;
    assign unusedSigs = ^{iHaveData, chosenHop, fSourceHops, fQValue,
                          fEnergyLeft, fHopsFromCH, fChosenCH, mNodeHops,
                          mNodeQValue, mNodeEnergy, mNodeCHHops, typeLat,
`ifndef REWARD_NBR_CHECK_EN
                          mNodeID, neighborCount,
`endif
                          destLat};

endmodule

// File: tb/tb_reward.sv
// Directed bench for reward with a queue scoreboard of expected replies.
module tb_reward;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en;
    logic [2:0]  fPacketType;
    logic [15:0] myEnergy, myNodeID, hopsFromSink, myQValue;
    logic        iHaveData, iAmDestination, role, low_E;
    logic [15:0] fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH;
    logic [15:0] chosenCH, hopsFromCH, chosenHop;
    logic [4:0]  neighborCount;
    logic [15:0] mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops;
    logic [15:0] rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rChosenCH, rHopsFromCH;
    logic [2:0]  rPacketType;
    logic [5:0]  nTableIndex_reward;
    logic        reward_done;

    logic [15:0] nbrIds [0:63];

    always #5 clk = ~clk;

    assign mNodeID     = nbrIds[nTableIndex_reward];
    assign mNodeHops   = 16'h0011;
    assign mNodeQValue = 16'h0022;
    assign mNodeEnergy = 16'h0033;
    assign mNodeCHHops = 16'h0044;

    reward #(.WORD_WIDTH(16)) dut (
        .clk(clk), .nrst(nrst), .en(en), .fPacketType(fPacketType),
        .myEnergy(myEnergy), .myNodeID(myNodeID), .hopsFromSink(hopsFromSink),
        .myQValue(myQValue), .iHaveData(iHaveData), .iAmDestination(iAmDestination),
        .role(role), .low_E(low_E), .fSourceID(fSourceID), .fSourceHops(fSourceHops),
        .fQValue(fQValue), .fEnergyLeft(fEnergyLeft), .fHopsFromCH(fHopsFromCH),
        .fChosenCH(fChosenCH), .chosenCH(chosenCH), .hopsFromCH(hopsFromCH),
        .chosenHop(chosenHop), .neighborCount(neighborCount), .mNodeID(mNodeID),
        .mNodeHops(mNodeHops), .mNodeQValue(mNodeQValue), .mNodeEnergy(mNodeEnergy),
        .mNodeCHHops(mNodeCHHops), .rSourceID(rSourceID), .rEnergyLeft(rEnergyLeft),
        .rQValue(rQValue), .rSourceHops(rSourceHops), .rDestinationID(rDestinationID),
        .rChosenCH(rChosenCH), .rHopsFromCH(rHopsFromCH), .rPacketType(rPacketType),
        .nTableIndex_reward(nTableIndex_reward), .reward_done(reward_done)
    );

    typedef struct {
        int          lat;
        int          scanCycles;
        logic [2:0]  ty;
        logic [15:0] src, nrg, q, hops, dst, ch, hch;
    } exp_t;

    exp_t sbq[$];
    exp_t hold;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic checkFields(input string name, input exp_t e);
        check({name, " rPacketType"}, 32'(rPacketType), 32'(e.ty));
        check({name, " rSourceID"}, 32'(rSourceID), 32'(e.src));
        check({name, " rEnergyLeft"}, 32'(rEnergyLeft), 32'(e.nrg));
        check({name, " rQValue"}, 32'(rQValue), 32'(e.q));
        check({name, " rSourceHops"}, 32'(rSourceHops), 32'(e.hops));
        check({name, " rDestinationID"}, 32'(rDestinationID), 32'(e.dst));
        check({name, " rChosenCH"}, 32'(rChosenCH), 32'(e.ch));
        check({name, " rHopsFromCH"}, 32'(rHopsFromCH), 32'(e.hch));
    endtask

    task automatic runOp(input string name, input logic [2:0] ty, input logic dst,
                         input logic [15:0] src, input logic [4:0] nc, input logic rl,
                         input logic le, input bit extraEn);
        exp_t e, got;
        bit   found, seen, spurious;
        int   k, c;
        @(negedge clk);
        fPacketType = ty; iAmDestination = dst; fSourceID = src;
        neighborCount = nc; role = rl; low_E = le; en = 1'b1;
        // reference model of the reply
        e = hold;
        e.scanCycles = 0;
        if (ty == 3'd5 && dst) begin
`ifdef REWARD_NBR_CHECK_EN
            found = 1'b0; k = 0;
            for (int i = 0; i < int'(nc); i++)
                if (!found && nbrIds[i] == src) begin found = 1'b1; k = i; end
`else
            found = 1'b1; k = -1;
`endif
            if (found) begin
                e.lat = k + 3;
                e.scanCycles = k + 1;
                e.src = myNodeID; e.nrg = myEnergy; e.q = myQValue;
                e.hops = hopsFromSink; e.dst = src;
                e.ch  = rl ? myNodeID : chosenCH;
                e.hch = rl ? 16'h0 : hopsFromCH;
                e.ty  = le ? 3'd7 : 3'd6;
            end else begin
                e.scanCycles = (nc == 5'd0) ? 1 : int'(nc);
                e.lat = e.scanCycles + 1;
                e.ty = 3'd0;
            end
        end else begin
            e.lat = 1;
            e.ty = 3'd0;
        end
        hold = e;
        sbq.push_back(e);
        c = 0; seen = 1'b0;
        while (!seen && c < 40) begin
            @(negedge clk);
            c++;
            en = extraEn && (c == 1);
`ifdef REWARD_NBR_CHECK_EN
            if (c <= e.scanCycles) check({name, " scan index"}, 32'(nTableIndex_reward), 32'(c - 1));
`else
            check({name, " index tied"}, 32'(nTableIndex_reward), 32'(0));
`endif
            if (reward_done) seen = 1'b1;
        end
        check({name, " done seen"}, 32'(seen), 32'(1));
        if (seen) begin
            got = sbq.pop_front();
            check({name, " latency"}, 32'(c), 32'(got.lat));
            checkFields(name, got);
        end
        @(negedge clk);
        en = 1'b0;
        check({name, " pulse width"}, 32'(reward_done), 32'(0));
        check({name, " index idle"}, 32'(nTableIndex_reward), 32'(0));
        if (extraEn) begin
            spurious = 1'b0;
            repeat (6) begin
                @(negedge clk);
                spurious |= reward_done;
            end
            check({name, " extra pulse"}, 32'(spurious), 32'(0));
        end
    endtask

    initial begin
        exp_t z;
        bit spurious;
        for (int i = 0; i < 64; i++) nbrIds[i] = 16'hFFFF;
        nrst = 1'b0; en = 1'b0; fPacketType = '0; myEnergy = '0; myNodeID = '0;
        hopsFromSink = '0; myQValue = '0; iHaveData = 1'b0; iAmDestination = 1'b0;
        role = 1'b0; low_E = 1'b0; fSourceID = '0; fSourceHops = 16'h0101;
        fQValue = 16'h0202; fEnergyLeft = 16'h0303; fHopsFromCH = 16'h0404;
        fChosenCH = 16'h0505; chosenCH = '0; hopsFromCH = '0; chosenHop = 16'h0606;
        neighborCount = '0;
        z.lat = 0; z.scanCycles = 0; z.ty = '0; z.src = '0; z.nrg = '0; z.q = '0;
        z.hops = '0; z.dst = '0; z.ch = '0; z.hch = '0;
        hold = z;

        repeat (3) @(negedge clk);
        check("reset reward_done", 32'(reward_done), 32'(0));
        check("reset index", 32'(nTableIndex_reward), 32'(0));
        checkFields("reset", z);
        nrst = 1'b1;
        @(negedge clk);

        myNodeID = 16'h000C; hopsFromSink = 16'h0001;
        runOp("ignored NONE", 3'd0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b0);

        nbrIds[0] = 16'h0003; nbrIds[1] = 16'h0005; nbrIds[2] = 16'h0007;
        myEnergy = 16'h8000; myQValue = 16'h1234; chosenCH = 16'h0002; hopsFromCH = 16'h0002;
        runOp("reward idx1", 3'd5, 1'b1, 16'h0005, 5'd3, 1'b0, 1'b0, 1'b0);
        runOp("sos head", 3'd5, 1'b1, 16'h0005, 5'd3, 1'b1, 1'b1, 1'b0);
        runOp("unknown sender", 3'd5, 1'b1, 16'h0009, 5'd3, 1'b0, 1'b0, 1'b0);
        runOp("empty table", 3'd5, 1'b1, 16'h0003, 5'd0, 1'b0, 1'b0, 1'b0);
        runOp("not destination", 3'd5, 1'b0, 16'h0005, 5'd3, 1'b0, 1'b0, 1'b0);
        myQValue = 16'hABCD;
        runOp("en during op", 3'd5, 1'b1, 16'h0003, 5'd3, 1'b0, 1'b0, 1'b1);
        myEnergy = 16'h0100; hopsFromSink = 16'h0004;
        runOp("last entry", 3'd5, 1'b1, 16'h0007, 5'd3, 1'b0, 1'b1, 1'b0);
        runOp("rx REWARD type", 3'd6, 1'b1, 16'h0005, 5'd3, 1'b0, 1'b0, 1'b0);

        // abort mid-operation with an asynchronous reset
        @(negedge clk);
        fPacketType = 3'd5; iAmDestination = 1'b1; fSourceID = 16'h0007;
        neighborCount = 5'd3; role = 1'b0; low_E = 1'b0; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        #2 nrst = 1'b0;
        #1;
        check("abort reward_done", 32'(reward_done), 32'(0));
        check("abort index", 32'(nTableIndex_reward), 32'(0));
        checkFields("abort", z);
        hold = z;
        @(negedge clk);
        nrst = 1'b1;
        spurious = 1'b0;
        repeat (8) begin
            @(negedge clk);
            spurious |= reward_done;
        end
        check("abort no pulse", 32'(spurious), 32'(0));

        myNodeID = 16'h0042; myEnergy = 16'h7777; myQValue = 16'h0F0F;
        hopsFromSink = 16'h0003; chosenCH = 16'h0009; hopsFromCH = 16'h0005;
        runOp("after reset", 3'd5, 1'b1, 16'h0005, 5'd3, 1'b1, 1'b0, 1'b0);

        check("scoreboard empty", 32'(sbq.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reward.md
Name: reward

Overview:
- Reply-packet builder for the EER-RL node controller.
- On each enable pulse it inspects the just-received packet. If the node is the destination of a DATA packet from a known neighbour, it assembles a REWARD packet back to the sender carrying own Q-value, energy, sink hops and cluster info.
- Sits between the packet filter/neighbour table and the transmit path.
- Signals completion with a one-cycle reward_done pulse.

Parameters:
- WORD_WIDTH, 16, width of all ID/hop/Q/energy fields.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- en  in  1  start pulse; sampled only in IDLE.
- fPacketType  in  3  received packet type: 0 NONE, 1 HB, 2 CHE, 3 INV, 4 JOIN, 5 DATA, 6 REWARD, 7 SOS.
- myEnergy, myNodeID, hopsFromSink, myQValue  in  16 each  own node info.
- iHaveData  in  1  node has pending data (status only, not used for decisions).
- iAmDestination  in  1  packet filter: this node is the addressee.
- role  in  1  1 = cluster head.
- low_E  in  1  own energy below threshold.
- fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH  in  16 each  received packet fields.
- chosenCH, hopsFromCH  in  16 each  known-CH info.
- chosenHop  in  16  current next hop (status only).
- neighborCount  in  5  valid neighbour-table entries.
- mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops  in  16 each  neighbour entry at nTableIndex_reward, combinational read, same cycle.
- rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rChosenCH, rHopsFromCH  out  16 each  outgoing packet fields, registered.
- rPacketType  out  3  outgoing packet type, registered.
- nTableIndex_reward  out  6  neighbour-table read index, registered.
- reward_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; latched fSourceID and type cleared.
- IDLE:
  - On en=1, latch fPacketType, fSourceID and iAmDestination.
  - If latched type==DATA and iAmDestination=1 -> SCAN, with nTableIndex_reward=0.
  - Otherwise -> DONE; r* outputs unchanged, rPacketType forced to 0 (NONE).
- SCAN:
  - Each cycle compare mNodeID with latched fSourceID.
  - On match -> BUILD; index holds.
  - No match: if index == neighborCount-1 -> DONE with rPacketType=0; else index+1.
  - neighborCount==0 -> DONE with rPacketType=0 on the first SCAN cycle.
- BUILD: one cycle, register:
  - rSourceID=myNodeID, rEnergyLeft=myEnergy, rQValue=myQValue, rSourceHops=hopsFromSink, rDestinationID=latched fSourceID.
  - rChosenCH/rHopsFromCH = myNodeID/0 if role=1, else chosenCH/hopsFromCH.
  - rPacketType = 7 (SOS) if low_E=1, else 6 (REWARD).
  - -> DONE.
- DONE: reward_done=1 for exactly one cycle; nTableIndex_reward returns to 0; -> IDLE.
- Outputs hold their last values between operations.
- en while not IDLE is ignored; no queuing.
- Latency from en edge to reward_done: match at index k -> k+3 cycles; ignored packet -> 1 cycle; unknown sender -> neighborCount+1 cycles.
- Reset mid-operation aborts immediately; reward_done never pulses for the aborted operation.
- No arithmetic; all fields pass through unmodified at full width.

Optional Feature:
- Macro REWARD_NBR_CHECK_EN.
- Defined: SCAN state present as above; rewards go to known neighbours only.
- Undefined: SCAN omitted; qualifying DATA goes IDLE -> BUILD -> DONE (latency 2); nTableIndex_reward tied to 0.

Test Plan:
- Reset, then en=1 with fPacketType=0, myNodeID=0x000C, hopsFromSink=1 -> reward_done pulses one cycle later; rPacketType=0; other r* stay 0.
- DATA, iAmDestination=1, fSourceID=0x0005, neighborCount=3, neighbour entry 1 ID=0x0005, myEnergy=0x8000, myQValue=0x1234, role=0, chosenCH=0x0002, hopsFromCH=2 -> rPacketType=6, rDestinationID=0x0005, rSourceID=0x000C, rEnergyLeft=0x8000, rChosenCH=0x0002, rHopsFromCH=2; reward_done at en+4 cycles.
- Same as previous but role=1 and low_E=1 -> rChosenCH=0x000C, rHopsFromCH=0, rPacketType=7.
- DATA from unknown ID 0x0009, neighborCount=3 -> index sweeps 0,1,2; reward_done with rPacketType=0; neighborCount=0 -> done after 1 SCAN cycle.
- DATA with iAmDestination=0, or en re-asserted during SCAN -> no REWARD; the second en is ignored; exactly one reward_done pulse per accepted en.
- nrst asserted during SCAN -> all outputs 0 asynchronously; no reward_done pulse follows.
